if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, bubble word inserted on flush.
REQ-003 SHALL have parameter MAX_STALL, default 4, consecutive-stall cycles that trip the watchdog.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port Stall  input  1  hold request from the hazard detection unit.
REQ-007 SHALL have port Flush  input  1  squash request from the hazard detection unit.
REQ-008 SHALL have port FwdPc  input  1  redirect PC to BranchTarget.
REQ-009 SHALL have port BranchTarget  input  32  redirect address.
REQ-010 SHALL have port InstrIn  input  32  instruction memory read data for PcOut (combinational memory).
REQ-011 SHALL have port PcOut  output  32  current fetch PC.
REQ-012 SHALL have port IfIdInstr  output  32  IF/ID instruction register.
REQ-013 SHALL have port IfIdPcPlus4  output  32  IF/ID PC+4 register.
REQ-014 SHALL have port IfIdValid  output  1  IF/ID holds a real instruction.
REQ-015 SHALL have port State  output  2  action of last edge: 2'b00 RUN, 2'b01 STALL, 2'b10 FLUSH.
REQ-016 SHALL have port StallCnt  output  16  total stall cycles, saturating.
REQ-017 SHALL have port FlushCnt  output  16  total flush cycles, saturating.
REQ-018 SHALL have port StallErr  output  1  sticky watchdog flag.

Function
REQ-019 Effective flush (EF) SHALL be Flush | FwdPc; per-edge priority RST > EF > Stall > RUN.
REQ-020 RUN (EF=0, Stall=0): PcOut <= PcOut+4; IfIdInstr <= InstrIn; IfIdPcPlus4 <= PcOut+4; IfIdValid <= 1; State <= RUN.
REQ-021 STALL (EF=0, Stall=1): PcOut, IfIdInstr, IfIdPcPlus4, IfIdValid SHALL hold; State <= STALL; StallCnt += 1.
REQ-022 FLUSH (EF=1): IfIdInstr <= NOP_INSTR; IfIdPcPlus4 <= 0; IfIdValid <= 0; State <= FLUSH; FlushCnt += 1.
REQ-023 In FLUSH, PcOut SHALL load {BranchTarget[31:2],2'b00} if FwdPc=1, else PcOut+4, regardless of Stall.
REQ-024 Flush and Stall asserted together SHALL act as FLUSH only; StallCnt and stall-run counter SHALL not advance.
REQ-025 Latency: InstrIn sampled at edge N SHALL appear on IfIdInstr immediately after edge N; no added cycles.
REQ-026 PC arithmetic SHALL be 32-bit modulo; PcOut=32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-027 StallCnt and FlushCnt SHALL saturate at 16'hFFFF, never wrap.
REQ-028 Internal stall-run counter SHALL increment each STALL edge, clear on any RUN or FLUSH edge, saturate at MAX_STALL.
REQ-029 StallErr SHALL set on the edge at which the stall-run counter reaches MAX_STALL and stay set until RST.
REQ-030 Outputs SHALL be driven directly from registers; no combinational input-to-output path.

Reset
REQ-031 On a rising edge with RST=1: PcOut=RESET_PC, IfIdInstr=NOP_INSTR, IfIdPcPlus4=0, IfIdValid=0, State=RUN, StallCnt=0, FlushCnt=0, stall-run=0, StallErr=0.
REQ-032 RST SHALL override Stall, Flush and FwdPc on the same edge, including mid-stall or mid-flush.
REQ-033 RST SHALL not act asynchronously; outputs keep their values until the next rising edge.

Verification
REQ-034 Reset, then 3 RUN edges with InstrIn=A,B,C -> PcOut=0x0C, IfIdInstr=C, IfIdPcPlus4=0x0C, IfIdValid=1, State=RUN.
REQ-035 Stall=1 for 2 edges at PcOut=0x08 -> PcOut stays 0x08, IF/ID unchanged, State=STALL, StallCnt=2, StallErr=0.
REQ-036 FwdPc=1, BranchTarget=0x0000_0103, Stall=1 -> PcOut=0x100, IfIdInstr=0, IfIdValid=0, State=FLUSH, FlushCnt+1, StallCnt unchanged.
REQ-037 Stall=1 for 4 consecutive edges -> StallErr=1 after 4th edge; stays 1 after Stall drops; cleared only by RST.
REQ-038 PcOut=0xFFFF_FFFC with RUN edge -> PcOut=0x0000_0000, IfIdPcPlus4=0x0000_0000.
REQ-039 RST=1 while Stall=1 and StallCnt=5 -> next edge all outputs at reset values of REQ-031.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Purpose : bundles the fetch-stage hazard controls, instruction-memory data
//           and the IF/ID register outputs into one port.
// Latency : pure wiring, no state.
// Backpressure: none here; the Stall/Flush lines carry all hold requests.
// Ports   : master = hazard unit / memory side (drives controls + InstrIn),
//           slave  = the fetch stage (drives PC, IF/ID register and status).
interface if_id_stage_if;
  logic        Stall;
  logic        Flush;
  logic        FwdPc;
  logic [31:0] BranchTarget;
  logic [31:0] InstrIn;
  logic [31:0] PcOut;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPcPlus4;
  logic        IfIdValid;
  logic [1:0]  State;
  logic [15:0] StallCnt;
  logic [15:0] FlushCnt;
  logic        StallErr;

  modport master (
    output Stall, Flush, FwdPc, BranchTarget, InstrIn,
    input  PcOut, IfIdInstr, IfIdPcPlus4, IfIdValid, State,
           StallCnt, FlushCnt, StallErr
  );

  modport slave (
    input  Stall, Flush, FwdPc, BranchTarget, InstrIn,
    output PcOut, IfIdInstr, IfIdPcPlus4, IfIdValid, State,
           StallCnt, FlushCnt, StallErr
  );
endinterface

// File: rtl/if_id_stage.sv
// Purpose : instruction fetch PC register plus IF/ID pipeline register with
//           stall/flush handling, event counters and a stall watchdog.
// Latency : InstrIn sampled on an edge is visible on IfIdInstr right after it.
// Backpressure: Stall holds PC and IF/ID; Flush/FwdPc override Stall and
//           squash IF/ID to a bubble.
// Ports   : CLK, RST (sync, active-high) plain; everything else via bus
//           (slave modport): controls/InstrIn in, PC/IF-ID/status out.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          MAX_STALL = 4
) (
  input  logic          CLK,
  input  logic          RST,
  if_id_stage_if.slave  bus
);

  localparam int RUN_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } action_t;

  action_t          stateQ, stateD;
  logic [31:0]      pcQ, pcD;
  logic [31:0]      instrQ, instrD;
  logic [31:0]      pcPlus4Q, pcPlus4D;
  logic             validQ, validD;
  logic [15:0]      stallCntQ, stallCntD;
  logic [15:0]      flushCntQ, flushCntD;
  logic [RUN_W-1:0] stallRunQ, stallRunD;
  logic             stallErrQ, stallErrD;

  logic        effFlush;
  logic [31:0] pcInc;

  // A PC redirect always discards the instruction fetched down the old path.
  assign effFlush = bus.Flush | bus.FwdPc;
  assign pcInc    = pcQ + 32'd4;

  // State register: records the action taken on the last edge.
  always_ff @(posedge CLK) begin
    if (RST) stateQ <= RUN;
    else     stateQ <= stateD;
  end

  // Next-state: flush beats stall beats run.
  always_comb begin
    stateD = RUN;
    if (effFlush)       stateD = FLUSH;
    else if (bus.Stall) stateD = STALL;
  end

  // Datapath next values for the chosen action.
  always_comb begin
    pcD       = pcQ;
    instrD    = instrQ;
    pcPlus4D  = pcPlus4Q;
    validD    = validQ;
    stallCntD = stallCntQ;
    flushCntD = flushCntQ;
    stallRunD = stallRunQ;
    stallErrD = stallErrQ;
    case (stateD)
      RUN: begin
        pcD       = pcInc;
        instrD    = bus.InstrIn;
        pcPlus4D  = pcInc;
        validD    = 1'b1;
        stallRunD = '0;
      end
      STALL: begin
        if (stallCntQ != 16'hFFFF) stallCntD = stallCntQ + 16'd1;
        if (stallRunQ != RUN_MAX)  stallRunD = stallRunQ + RUN_W'(1);
        if (stallRunD == RUN_MAX)  stallErrD = 1'b1;
      end
      FLUSH: begin
        // Masking keeps the redirect word aligned.
        pcD       = bus.FwdPc ? (bus.BranchTarget & ~32'd3) : pcInc;
        instrD    = NOP_INSTR;
        pcPlus4D  = 32'd0;
        validD    = 1'b0;
        stallRunD = '0;
        if (flushCntQ != 16'hFFFF) flushCntD = flushCntQ + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pcQ       <= RESET_PC;
      instrQ    <= NOP_INSTR;
      pcPlus4Q  <= 32'd0;
      validQ    <= 1'b0;
      stallCntQ <= 16'd0;
      flushCntQ <= 16'd0;
      stallRunQ <= '0;
      stallErrQ <= 1'b0;
    end else begin
      pcQ       <= pcD;
      instrQ    <= instrD;
      pcPlus4Q  <= pcPlus4D;
      validQ    <= validD;
      stallCntQ <= stallCntD;
      flushCntQ <= flushCntD;
      stallRunQ <= stallRunD;
      stallErrQ <= stallErrD;
    end
  end

  assign bus.PcOut       = pcQ;
  assign bus.IfIdInstr   = instrQ;
  assign bus.IfIdPcPlus4 = pcPlus4Q;
  assign bus.IfIdValid   = validQ;
  assign bus.State       = stateQ;
  assign bus.StallCnt    = stallCntQ;
  assign bus.FlushCnt    = flushCntQ;
  assign bus.StallErr    = stallErrQ;

endmodule

// File: tb/tb_if_id_stage.sv
// Purpose : directed vectors for if_id_stage with a queue-based scoreboard.
// Latency : each vector is checked 1 time unit after the edge it drives.
// Backpressure: n/a; every edge produces one expected record.
module tb_if_id_stage;

  localparam logic [31:0] I_A = 32'h1111_0001;
  localparam logic [31:0] I_B = 32'h2222_0002;
  localparam logic [31:0] I_C = 32'h3333_0003;
  localparam logic [31:0] I_D = 32'hDEAD_BEEF;
  localparam logic [31:0] I_E = 32'h5555_0005;
  localparam logic [31:0] I_F = 32'h6666_0006;
  localparam logic [31:0] I_G = 32'h7777_0007;
  localparam logic [1:0]  S_R = 2'b00;
  localparam logic [1:0]  S_S = 2'b01;
  localparam logic [1:0]  S_F = 2'b10;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  if_id_stage_if bus();

  if_id_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000),
    .MAX_STALL (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        vld;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        err;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   pushed     = 0;
  int   popped     = 0;

  task automatic chk(input string tag, input string field,
                     input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s.%s: got %h, want %h", tag, field, act, want);
    end
  endtask

  // Drive one edge's inputs and queue the hand-computed post-edge state.
  task automatic step(input string tag, input logic r, s, f, fw,
                      input logic [31:0] bt, ins,
                      input logic [31:0] pc, instr, pp4,
                      input logic vld, input logic [1:0] st,
                      input logic [15:0] sc, fc, input logic err);
    exp_t e;
    @(negedge CLK);
    RST              = r;
    bus.Stall        = s;
    bus.Flush        = f;
    bus.FwdPc        = fw;
    bus.BranchTarget = bt;
    bus.InstrIn      = ins;
    e.tag = tag; e.pc = pc; e.instr = instr; e.pp4 = pp4; e.vld = vld;
    e.st = st; e.sc = sc; e.fc = fc; e.err = err;
    expQ.push_back(e);
    pushed++;
  endtask

  // Monitor: every edge with a pending expectation is compared field by field.
  exp_t m;
  always @(posedge CLK) begin
    #1;
    if (expQ.size() != 0) begin
      m = expQ.pop_front();
      popped++;
      chk(m.tag, "PcOut",       bus.PcOut,              m.pc);
      chk(m.tag, "IfIdInstr",   bus.IfIdInstr,          m.instr);
      chk(m.tag, "IfIdPcPlus4", bus.IfIdPcPlus4,        m.pp4);
      chk(m.tag, "IfIdValid",   32'(bus.IfIdValid),     32'(m.vld));
      chk(m.tag, "State",       32'(bus.State),         32'(m.st));
      chk(m.tag, "StallCnt",    32'(bus.StallCnt),      32'(m.sc));
      chk(m.tag, "FlushCnt",    32'(bus.FlushCnt),      32'(m.fc));
      chk(m.tag, "StallErr",    32'(bus.StallErr),      32'(m.err));
    end
  end

  initial begin
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.FwdPc = 1'b0;
    bus.BranchTarget = 32'd0; bus.InstrIn = 32'd0;

    //    tag          r  s  f  fw bt            ins   pc            instr pp4           v  st   sc  fc  err
    step("rst0",       1, 1, 0, 0, 32'h0,        I_D,  32'h0,        32'h0, 32'h0,       0, S_R, 0,  0,  0);
    step("runA",       0, 0, 0, 0, 32'h0,        I_A,  32'h4,        I_A,   32'h4,       1, S_R, 0,  0,  0);
    step("runB",       0, 0, 0, 0, 32'h0,        I_B,  32'h8,        I_B,   32'h8,       1, S_R, 0,  0,  0);
    step("stall1",     0, 1, 0, 0, 32'h0,        I_D,  32'h8,        I_B,   32'h8,       1, S_S, 1,  0,  0);
    step("stall2",     0, 1, 0, 0, 32'h0,        I_D,  32'h8,        I_B,   32'h8,       1, S_S, 2,  0,  0);
    step("runC",       0, 0, 0, 0, 32'h0,        I_C,  32'hC,        I_C,   32'hC,       1, S_R, 2,  0,  0);
    step("fwdStall",   0, 1, 0, 1, 32'h103,      I_D,  32'h100,      32'h0, 32'h0,       0, S_F, 2,  1,  0);
    step("flush",      0, 0, 1, 0, 32'h0,        I_D,  32'h104,      32'h0, 32'h0,       0, S_F, 2,  2,  0);
    step("runE",       0, 0, 0, 0, 32'h0,        I_E,  32'h108,      I_E,   32'h108,     1, S_R, 2,  2,  0);
    step("stlA",       0, 1, 0, 0, 32'h0,        I_D,  32'h108,      I_E,   32'h108,     1, S_S, 3,  2,  0);
    step("stlB",       0, 1, 0, 0, 32'h0,        I_D,  32'h108,      I_E,   32'h108,     1, S_S, 4,  2,  0);
    step("stlC",       0, 1, 0, 0, 32'h0,        I_D,  32'h108,      I_E,   32'h108,     1, S_S, 5,  2,  0);
    step("flushStall", 0, 1, 1, 0, 32'h0,        I_D,  32'h10C,      32'h0, 32'h0,       0, S_F, 5,  3,  0);
    step("wd1",        0, 1, 0, 0, 32'h0,        I_D,  32'h10C,      32'h0, 32'h0,       0, S_S, 6,  3,  0);
    step("wd2",        0, 1, 0, 0, 32'h0,        I_D,  32'h10C,      32'h0, 32'h0,       0, S_S, 7,  3,  0);
    step("wd3",        0, 1, 0, 0, 32'h0,        I_D,  32'h10C,      32'h0, 32'h0,       0, S_S, 8,  3,  0);
    step("wd4",        0, 1, 0, 0, 32'h0,        I_D,  32'h10C,      32'h0, 32'h0,       0, S_S, 9,  3,  1);
    step("wd5",        0, 1, 0, 0, 32'h0,        I_D,  32'h10C,      32'h0, 32'h0,       0, S_S, 10, 3,  1);
    step("runF",       0, 0, 0, 0, 32'h0,        I_F,  32'h110,      I_F,   32'h110,     1, S_R, 10, 3,  1);
    step("rstMid",     1, 1, 1, 1, 32'h55,       I_D,  32'h0,        32'h0, 32'h0,       0, S_R, 0,  0,  0);
    // RST is raised but no edge has happened yet: outputs must not move.
    #2;
    chk("rstSync", "PcOut",    bus.PcOut,           32'h110);
    chk("rstSync", "StallErr", 32'(bus.StallErr),   32'd1);
    step("wrapFwd",    0, 0, 0, 1, 32'hFFFF_FFFF, I_D, 32'hFFFF_FFFC, 32'h0, 32'h0,       0, S_F, 0,  1,  0);
    step("wrapRun",    0, 0, 0, 0, 32'h0,        I_G,  32'h0,        I_G,   32'h0,       1, S_R, 0,  1,  0);

    @(negedge CLK);
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.FwdPc = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    chk("drain", "popped", 32'(popped), 32'(pushed));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
